// File: rtl/quick_spi_pkg.sv
// quick_spi_pkg: shared FSM encoding, command-entry layout and field widths for the SPI command sequencer
package quick_spi_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_EOT, RESPOND} state_t;
  localparam int SLAVE_WIDTH = 2;
  localparam int DATA_OUT_WIDTH = 16;
  localparam int DATA_IN_WIDTH = 8;
  localparam int CMD_WIDTH = 19;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_SLAVE_LSB = 16;
  localparam int CMD_WRITE_BIT = 18;
  function automatic logic [CMD_WIDTH-1:0] pack_cmd(input logic w, input logic [SLAVE_WIDTH-1:0] s, input logic [DATA_OUT_WIDTH-1:0] d);
    return {w, s, d};
  endfunction
endpackage

// File: rtl/quick_spi_cmd_fifo.sv
// quick_spi_cmd_fifo: synchronous FIFO (clk, async reset, push/wdata in, pop/rdata out, full/empty/count status)
module quick_spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];
endmodule

// File: rtl/quick_spi_cmd_sequencer.sv
// quick_spi_cmd_sequencer: queues SPI commands, launches them one at a time on an SPI master, returns read data, flags EOT timeouts
module quick_spi_cmd_sequencer
  import quick_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [SLAVE_WIDTH-1:0]    cmd_slave,
  input  logic [DATA_OUT_WIDTH-1:0] cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_IN_WIDTH-1:0]  rsp_data,
  output logic [SLAVE_WIDTH-1:0]    rsp_slave,
  output logic                      spi_enable,
  output logic                      spi_start_transaction,
  output logic [SLAVE_WIDTH-1:0]    spi_slave,
  output logic                      spi_operation,
  output logic [DATA_OUT_WIDTH-1:0] spi_outgoing_data,
  input  logic                      spi_end_of_transaction,
  input  logic [DATA_IN_WIDTH-1:0]  spi_incoming_data,
  output logic                      busy,
  output logic                      timeout_error,
  input  logic                      error_clear
);
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d, fifo_rdata;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DATA_IN_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [SLAVE_WIDTH-1:0] rsp_slave_q, rsp_slave_d;
  logic err_q, err_d, timeout;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  assign cmd_ready = ~fifo_full & ~reset;
  assign fifo_push = cmd_valid & cmd_ready;
  quick_spi_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_WIDTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(fifo_push),
    .pop(fifo_pop),
    .wdata(pack_cmd(cmd_write, cmd_slave, cmd_data)),
    .rdata(fifo_rdata),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_slave_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_slave_q <= rsp_slave_d;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_slave_d = rsp_slave_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        state_d = LAUNCH;
        cmd_d = fifo_rdata;
      end
      LAUNCH: begin
        state_d = WAIT_EOT;
        cnt_d = '0;
      end
      WAIT_EOT: if (spi_end_of_transaction) begin
        state_d = cmd_q[CMD_WRITE_BIT] ? IDLE : RESPOND;
        rsp_data_d = cmd_q[CMD_WRITE_BIT] ? rsp_data_q : spi_incoming_data;
        rsp_slave_d = cmd_q[CMD_WRITE_BIT] ? rsp_slave_q : cmd_q[CMD_SLAVE_LSB +: SLAVE_WIDTH];
      end else if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESPOND: state_d = rsp_ready ? IDLE : RESPOND;
    endcase
    // a timeout in the same cycle as error_clear keeps the flag set
    err_d = timeout | (err_q & ~error_clear);
  end
  always_comb begin
    fifo_pop = (state_q == IDLE) & ~fifo_empty;
    spi_start_transaction = state_q == LAUNCH;
    rsp_valid = state_q == RESPOND;
    busy = (state_q != IDLE) | (fifo_count != '0);
  end
  assign spi_enable = ~reset;
  assign spi_slave = cmd_q[CMD_SLAVE_LSB +: SLAVE_WIDTH];
  assign spi_operation = cmd_q[CMD_WRITE_BIT];
  assign spi_outgoing_data = cmd_q[CMD_DATA_LSB +: DATA_OUT_WIDTH];
  assign rsp_data = rsp_data_q;
  assign rsp_slave = rsp_slave_q;
  assign timeout_error = err_q;
endmodule

// File: tb/tb_quick_spi_cmd_sequencer.sv
// tb_quick_spi_cmd_sequencer: directed and randomized checks of the sequencer against a transaction-level command queue model
module tb_quick_spi_cmd_sequencer;
  localparam int TO = 48;
  typedef struct packed {logic w; logic [1:0] s; logic [15:0] d;} cmd_t;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_write = 0, rsp_ready = 0, eot = 0, error_clear = 0;
  logic [1:0] cmd_slave = 0;
  logic [15:0] cmd_data = 0;
  logic [7:0] din = 0;
  logic cmd_ready, rsp_valid, spi_enable, spi_start_transaction, spi_operation, busy, timeout_error;
  logic [7:0] rsp_data;
  logic [1:0] rsp_slave, spi_slave;
  logic [15:0] spi_outgoing_data;
  int checks = 0, failures = 0, last_n;
  cmd_t exp_q[$];
  cmd_t cur, c;
  quick_spi_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_slave(cmd_slave), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
    .spi_enable(spi_enable), .spi_start_transaction(spi_start_transaction), .spi_slave(spi_slave),
    .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(eot), .spi_incoming_data(din),
    .busy(busy), .timeout_error(timeout_error), .error_clear(error_clear)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic cmd_t rnd_cmd();
    logic [31:0] r;
    r = $urandom;
    return r[18:0];
  endfunction
  task automatic push(input cmd_t p, input logic exp_rdy);
    cmd_valid = 1;
    cmd_write = p.w;
    cmd_slave = p.s;
    cmd_data = p.d;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    if (exp_rdy) exp_q.push_back(p);
    tick;
    cmd_valid = 0;
  endtask
  task automatic wait_start(output int n);
    n = 0;
    while (spi_start_transaction !== 1'b1 && n < 12) begin
      tick;
      n++;
    end
    chk("start_seen", 32'(spi_start_transaction), 32'(1));
  endtask
  task automatic take_head;
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    chk("spi_operation", 32'(spi_operation), 32'(cur.w));
    chk("spi_slave", 32'(spi_slave), 32'(cur.s));
    chk("spi_outgoing_data", 32'(spi_outgoing_data), 32'(cur.d));
  endtask
  task automatic do_eot(input int d, input logic [7:0] data);
    for (int i = 0; i < d; i++) begin
      tick;
      chk("start_one_pulse", 32'(spi_start_transaction), 32'(0));
      chk("out_stable", 32'(spi_outgoing_data), 32'(cur.d));
    end
    eot = 1;
    din = data;
    tick;
    eot = 0;
  endtask
  task automatic serve(input int d, input logic [7:0] data, input int hold, input int exp_n);
    wait_start(last_n);
    if (exp_n >= 0) chk("latency", 32'(last_n), 32'(exp_n));
    take_head;
    do_eot(d, data);
    if (!cur.w) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(1));
      chk("rsp_data", 32'(rsp_data), 32'(data));
      chk("rsp_slave", 32'(rsp_slave), 32'(cur.s));
      for (int i = 0; i < hold; i++) begin
        tick;
        chk("rsp_valid_hold", 32'(rsp_valid), 32'(1));
        chk("rsp_data_hold", 32'(rsp_data), 32'(data));
        chk("rsp_slave_hold", 32'(rsp_slave), 32'(cur.s));
      end
      rsp_ready = 1;
      tick;
      rsp_ready = 0;
      chk("rsp_valid_done", 32'(rsp_valid), 32'(0));
    end else begin
      chk("no_rsp_for_write", 32'(rsp_valid), 32'(0));
    end
  endtask
  initial begin
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_spi_enable", 32'(spi_enable), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_start", 32'(spi_start_transaction), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_out_data", 32'(spi_outgoing_data), 32'(0));
    chk("rst_error", 32'(timeout_error), 32'(0));
    repeat (2) tick;
    reset = 0;
    tick;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("post_rst_spi_enable", 32'(spi_enable), 32'(1));
    // single write, EOT 40 cycles after start
    push('{w: 1'b1, s: 2'b01, d: 16'h5A6A}, 1);
    serve(40, 8'h00, 0, 1);
    chk("write_idle_busy", 32'(busy), 32'(0));
    // read with delayed response handshake
    c = rnd_cmd();
    c.w = 0;
    c.s = 2'b10;
    push(c, 1);
    serve(3, 8'h95, 5, 1);
    chk("read_idle_busy", 32'(busy), 32'(0));
    // fill the queue during a long transaction
    c = rnd_cmd();
    c.w = 1;
    push(c, 1);
    wait_start(last_n);
    take_head;
    tick;
    for (int i = 0; i < 5; i++) push(rnd_cmd(), i < 4);
    eot = 1;
    tick;
    eot = 0;
    for (int i = 0; i < 4; i++) serve($urandom_range(1, 8), 8'($urandom), $urandom_range(0, 3), 1);
    chk("drain_busy", 32'(busy), 32'(0));
    // timeout, then next queued command, then clear/timeout collision
    c = rnd_cmd();
    c.w = 0;
    push(c, 1);
    push(rnd_cmd(), 1);
    wait_start(last_n);
    take_head;
    repeat (TO) tick;
    chk("err_before_timeout", 32'(timeout_error), 32'(0));
    tick;
    chk("err_at_timeout", 32'(timeout_error), 32'(1));
    chk("timeout_no_rsp", 32'(rsp_valid), 32'(0));
    wait_start(last_n);
    chk("next_after_timeout", 32'(last_n), 32'(1));
    take_head;
    repeat (TO) tick;
    chk("err_sticky", 32'(timeout_error), 32'(1));
    error_clear = 1;
    tick;
    error_clear = 0;
    chk("clear_vs_timeout", 32'(timeout_error), 32'(1));
    error_clear = 1;
    tick;
    error_clear = 0;
    chk("err_cleared", 32'(timeout_error), 32'(0));
    // EOT on the exact timeout cycle wins
    c = rnd_cmd();
    c.w = 0;
    push(c, 1);
    serve(TO, 8'($urandom), 1, 1);
    chk("eot_wins_no_err", 32'(timeout_error), 32'(0));
    chk("eot_wins_busy", 32'(busy), 32'(0));
    // randomized traffic with stray EOTs while idle
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        eot = 1;
        din = 8'($urandom);
        tick;
        eot = 0;
        chk("stray_eot_start", 32'(spi_start_transaction), 32'(0));
        chk("stray_eot_busy", 32'(busy), 32'(0));
      end
      push(rnd_cmd(), 1);
      serve($urandom_range(1, TO), 8'($urandom), $urandom_range(0, 4), 1);
      chk("rand_busy", 32'(busy), 32'(0));
      chk("rand_no_err", 32'(timeout_error), 32'(0));
    end
    // reset in WAIT_EOT with two queued commands
    push(rnd_cmd(), 1);
    wait_start(last_n);
    take_head;
    tick;
    push(rnd_cmd(), 1);
    push(rnd_cmd(), 1);
    #2 reset = 1;
    #1;
    exp_q.delete();
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("mid_rst_spi_enable", 32'(spi_enable), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_start", 32'(spi_start_transaction), 32'(0));
    chk("mid_rst_slave", 32'(spi_slave), 32'(0));
    chk("mid_rst_op", 32'(spi_operation), 32'(0));
    chk("mid_rst_out_data", 32'(spi_outgoing_data), 32'(0));
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("mid_rst_rsp_slave", 32'(rsp_slave), 32'(0));
    chk("mid_rst_error", 32'(timeout_error), 32'(0));
    tick;
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("post_rst_no_start", 32'(spi_start_transaction), 32'(0));
      chk("post_rst_busy", 32'(busy), 32'(0));
    end
    push(rnd_cmd(), 1);
    serve(5, 8'($urandom), 0, 1);
    chk("final_busy", 32'(busy), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
